// File: rtl/lal_count_driver.sv
// lal_count_driver
//   Holds the count field and the key pair that the combinational lal
//   next-state/compare logic evaluates. It runs a count from a start request
//   to a one-cycle done pulse. The count advances only while the sampled key
//   matches the key that was latched at start.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   start    : run request, accepted only in IDLE (abort low)
//   abort    : cancel the current run (IDLE wins over start; ignored in DONE)
//   hold     : freeze counting in RUN
//   term     : terminal count, captured on start acceptance
//   key_ref  : reference key, captured on start acceptance
//   key_smp  : live sample key, compared every cycle
//   busy     : high while in RUN
//   done     : one-cycle pulse in DONE
//   count    : registered count value
//   match    : registered key_smp == key_ref_q
//   stall    : registered flag: last RUN edge held the count (hold or mismatch)
module lal_count_driver #(
  parameter int CNT_W = 9,
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [CNT_W-1:0] term,
  input  logic [KEY_W-1:0] key_ref,
  input  logic [KEY_W-1:0] key_smp,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             match,
  output logic             stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] term_q;
  logic [KEY_W-1:0] key_ref_q;
  logic             at_term;
  logic             blocked;

  assign at_term = (count == term_q);
  assign blocked = hold || (key_smp != key_ref_q);

  // busy/done decode straight from the state register, so neither has a
  // combinational path from any input.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      term_q    <= '0;
      key_ref_q <= '0;
      match     <= 1'b0;
      stall     <= 1'b0;
    end else begin
      // match uses the key_ref_q value held before this edge, even on the
      // edge that captures a new reference.
      match <= (key_smp == key_ref_q);
      stall <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            term_q    <= term;
            key_ref_q <= key_ref;
            count     <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          // Priority: abort, then terminal check, then stall, then advance.
          // The terminal check sitting above the stall is what lets DONE be
          // taken while hold is high.
          if (abort) begin
            state <= IDLE;
          end else if (at_term) begin
            state <= DONE;
          end else if (blocked) begin
            stall <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
